// File: rtl/lram_fifo.sv
// First-word-fall-through FIFO: DEPTH-entry LUT-RAM (async read, sync write)
// feeding one output register; total capacity DEPTH+1 words.
module lram_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic             mem_empty;
   logic             or_load;
   logic             mem_rd;
   logic             bypass;
   logic             mem_wr;
   logic [AW:0]      count_nxt;

   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   // words in LUT-RAM = count minus the one held in the output register
   assign mem_empty = (count == {{AW{1'b0}}, out_valid});
   assign or_load   = ~out_valid | out_ready;
   assign mem_rd    = or_load & ~mem_empty;
   assign bypass    = or_load & mem_empty & push;
   assign mem_wr    = push & ~bypass & ~clear;

   always_comb begin
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   // storage has no reset: stale entries are never exposed past out_valid
   always_ff @(posedge clock) begin
      if (mem_wr) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         count     <= '0;
         in_ready  <= 1'b1;
      end else begin
         if (mem_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (mem_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (or_load) begin
            out_valid <= mem_rd | bypass;
            if (mem_rd) begin
               out_data <= mem[rd_ptr];
            end else if (bypass) begin
               out_data <= in_data;
            end
         end
         count    <= count_nxt;
         in_ready <= (count_nxt != FULL);
      end
   end

endmodule
